aes_req_sched: RTL and testbench

Round-robin scheduler that shares one iterative `aes` core between `NREQ` independent requesters. It sits directly in front of the core. It arbitrates requests, loads key/data/direction into the core, and holds those inputs stable for the whole operation. It then captures the single-cycle `ready` result and returns it on a back-pressured response channel tagged with the requester ID.

---
 rtl/aes_sched_pkg.sv | 19 +
 rtl/aes_rr_arb.sv | 34 +++
 rtl/aes_req_sched.sv | 140 ++++++++++++++
 tb/tb_aes_req_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES request scheduler: block width, scheduler
// state encoding and the requester-ID width helper.
package aes_sched_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } sched_state_t;

    // Requester ID width; never below one bit so a 1-wide bus always exists.
    function automatic int idw_f(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_rr_arb.sv
// Combinational round-robin arbiter. The search starts one past the last
// winner and wraps; the pointer itself is owned by the caller.
module aes_rr_arb
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    logic [IDW-1:0] w_idx;

    // First valid requester found walking forward from last+1 wins.
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(i_last) + k) % NREQ);
            if (!o_any && i_valid[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = w_idx;
            end
        end
    end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one iterative AES core between NREQ requesters. A request is
// captured into holding registers on grant, the core is loaded for one
// cycle, and the single-cycle core result is parked on a back-pressured
// response channel tagged with the owning requester.
//
// state | meaning
// IDLE  | arbitrating; grant is offered combinationally on req_ready_o
// LOAD  | core_load_o high for one cycle with held key/data/direction
// BUSY  | waiting for the core completion pulse
// RESP  | response registered and presented until accepted
module aes_req_sched
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ-1:0]          req_decrypt_i,
    input  logic [NREQ*AES_BLK_W-1:0] req_data_i,
    input  logic [NREQ*AES_BLK_W-1:0] req_key_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic                     core_load_o,
    output logic                     core_decrypt_o,
    output logic [AES_BLK_W-1:0]     core_data_o,
    output logic [AES_BLK_W-1:0]     core_key_o,
    input  logic                     core_ready_i,
    input  logic [AES_BLK_W-1:0]     core_data_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IDW-1:0]           rsp_id_o,
    output logic                     rsp_decrypt_o,
    output logic [AES_BLK_W-1:0]     rsp_data_o,
    output logic                     busy_o
);

    sched_state_t         r_state;
    logic [IDW-1:0]       r_last;
    logic [AES_BLK_W-1:0] r_hold_data;
    logic [AES_BLK_W-1:0] r_hold_key;
    logic                 r_hold_dec;
    logic [IDW-1:0]       r_hold_id;
    logic                 r_core_load;
    logic                 r_rsp_valid;
    logic [IDW-1:0]       r_rsp_id;
    logic                 r_rsp_dec;
    logic [AES_BLK_W-1:0] r_rsp_data;

    logic [NREQ-1:0]      w_gnt;
    logic [IDW-1:0]       w_gnt_id;
    logic                 w_any;
    logic [AES_BLK_W-1:0] w_slot_data [NREQ];
    logic [AES_BLK_W-1:0] w_slot_key  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign w_slot_data[g] = req_data_i[g*AES_BLK_W +: AES_BLK_W];
        assign w_slot_key[g]  = req_key_i[g*AES_BLK_W +: AES_BLK_W];
    end

    aes_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_valid (req_valid_i),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_id    (w_gnt_id),
        .o_any   (w_any)
    );

    // Scheduler FSM with its holding, pointer and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_hold_data <= '0;
            r_hold_key  <= '0;
            r_hold_dec  <= 1'b0;
            r_hold_id   <= '0;
            r_core_load <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_dec   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_core_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_hold_data <= w_slot_data[w_gnt_id];
                        r_hold_key  <= w_slot_key[w_gnt_id];
                        r_hold_dec  <= req_decrypt_i[w_gnt_id];
                        r_hold_id   <= w_gnt_id;
                        r_last      <= w_gnt_id;
                        r_core_load <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (core_ready_i) begin
                        r_rsp_data  <= core_data_i;
                        r_rsp_id    <= r_hold_id;
                        r_rsp_dec   <= r_hold_dec;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Grant is offered only while arbitrating; holding registers feed the
    // core continuously because it re-reads key and direction every round.
    always_comb begin
        req_ready_o    = (r_state == ST_IDLE) ? w_gnt : '0;
        core_load_o    = r_core_load;
        core_decrypt_o = r_hold_dec;
        core_data_o    = r_hold_data;
        core_key_o     = r_hold_key;
        rsp_valid_o    = r_rsp_valid;
        rsp_id_o       = r_rsp_id;
        rsp_decrypt_o  = r_rsp_dec;
        rsp_data_o     = r_rsp_data;
        busy_o         = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Scoreboard bench for aes_req_sched: a behavioural core stands in for the
// AES engine, stimulus pushes expected responses, a monitor pops and checks.
module tb_aes_req_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [IDW-1:0] id;
        logic           dec;
        logic [127:0]   data;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_decrypt_i;
    logic [NREQ*128-1:0] req_data_i;
    logic [NREQ*128-1:0] req_key_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              core_load_o;
    logic              core_decrypt_o;
    logic [127:0]      core_data_o;
    logic [127:0]      core_key_o;
    logic              core_ready_i;
    logic [127:0]      core_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [IDW-1:0]    rsp_id_o;
    logic              rsp_decrypt_o;
    logic [127:0]      rsp_data_o;
    logic              busy_o;

    logic [127:0] s_data [NREQ];
    logic [127:0] s_key  [NREQ];
    int           n_left [NREQ];
    exp_t         exp_q[$];
    int           grant_log[$];
    int           grant_cyc[$];
    int           total;
    int           bad;
    int           cyc;
    int           last_rsp_cyc;
    int           core_lat;
    int           spur_cnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_data_i[g*128 +: 128] = s_data[g];
        assign req_key_i[g*128 +: 128]  = s_key[g];
    end

    aes_req_sched #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_decrypt_i  (req_decrypt_i),
        .req_data_i     (req_data_i),
        .req_key_i      (req_key_i),
        .req_ready_o    (req_ready_o),
        .core_load_o    (core_load_o),
        .core_decrypt_o (core_decrypt_o),
        .core_data_o    (core_data_o),
        .core_key_o     (core_key_o),
        .core_ready_i   (core_ready_i),
        .core_data_i    (core_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_id_o       (rsp_id_o),
        .rsp_decrypt_o  (rsp_decrypt_o),
        .rsp_data_o     (rsp_data_o),
        .busy_o         (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    // Known FIPS-197 pair, otherwise a simple reversible stand-in transform.
    function automatic logic [127:0] ref_core(input logic [127:0] k, input logic [127:0] d, input logic dec);
        if (!dec && k == FK && d == FP) return FC;
        if (dec && k == FK && d == FC) return FP;
        return d ^ k ^ {128{dec}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready_o), 0);
        chk({tag, "_core_load"}, 128'(core_load_o), 0);
        chk({tag, "_core_dec"}, 128'(core_decrypt_o), 0);
        chk({tag, "_core_data"}, core_data_o, 0);
        chk({tag, "_core_key"}, core_key_o, 0);
        chk({tag, "_rsp_valid"}, 128'(rsp_valid_o), 0);
        chk({tag, "_rsp_id"}, 128'(rsp_id_o), 0);
        chk({tag, "_rsp_dec"}, 128'(rsp_decrypt_o), 0);
        chk({tag, "_rsp_data"}, rsp_data_o, 0);
        chk({tag, "_busy"}, 128'(busy_o), 0);
    endtask

    // Behavioural core: samples the load strobe, answers after core_lat cycles.
    initial begin
        logic         pend;
        int           cnt;
        int           spur_done;
        logic [127:0] res;
        pend = 1'b0; cnt = 0; spur_done = 0; res = '0;
        core_ready_i = 1'b0;
        core_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            core_ready_i = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else if (core_load_o) begin
                pend = 1'b1;
                cnt  = core_lat;
                res  = ref_core(core_key_o, core_data_o, core_decrypt_o);
            end else if (pend) begin
                if (cnt <= 1) begin
                    core_ready_i = 1'b1;
                    core_data_i  = res;
                    pend         = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (spur_cnt != spur_done) begin
                core_ready_i = 1'b1;
                core_data_i  = 128'hdeadbeef_cafef00d_0badc0de_12345678;
                spur_done    = spur_cnt;
            end
        end
    end

    // Monitor: load strobe timing, grant legality, response scoreboard.
    initial begin
        logic load_due;
        exp_t e;
        load_due = 1'b0;
        forever begin
            @(negedge clk);
            chk("core_load_timing", 128'(core_load_o), 128'(load_due));
            load_due = |(req_valid_i & req_ready_o);
            if (req_ready_o != '0)
                chk("grant_onehot_idle", {126'd0, $onehot(req_ready_o), busy_o}, 128'b10);
            if (rsp_valid_o && rsp_ready_i) begin
                last_rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got id %0d data %h want none", rsp_id_o, rsp_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 128'(rsp_id_o), 128'(e.id));
                    chk("rsp_dec", 128'(rsp_decrypt_o), 128'(e.dec));
                    chk("rsp_data", rsp_data_o, e.data);
                end
            end
        end
    end

    // Offer mask until each requester has been granted n_left times.
    task automatic batch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] hs;
        int guard;
        exp_t e;
        grant_log.delete();
        grant_cyc.delete();
        req_valid_i = mask;
        guard = 0;
        while (req_valid_i != '0) begin
            @(negedge clk);
            hs = req_valid_i & req_ready_o;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    grant_log.push_back(i);
                    grant_cyc.push_back(cyc);
                    e.id   = IDW'(i);
                    e.dec  = req_decrypt_i[i];
                    e.data = ref_core(s_key[i], s_data[i], req_decrypt_i[i]);
                    exp_q.push_back(e);
                    n_left[i]--;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++)
                if (hs[i] && n_left[i] <= 0) req_valid_i[i] = 1'b0;
            guard++;
            if (guard > 2000) begin
                chk("batch_timeout", 128'(req_valid_i), 0);
                req_valid_i = '0;
            end
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy_o) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("idle_timeout", 128'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_pr [3] = '{0, 1, 3};
        logic [127:0] held;
        int ok;
        total = 0; bad = 0; spur_cnt = 0; core_lat = 1; last_rsp_cyc = -1;
        reset = 1'b0;
        req_valid_i = '0; req_decrypt_i = '0; rsp_ready_i = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            s_data[i] = '0; s_key[i] = '0; n_left[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("rst_init");
        reset = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 encrypt on requester 0, single-cycle core.
        s_key[0] = FK; s_data[0] = FP; req_decrypt_i[0] = 1'b0; n_left[0] = 1;
        core_lat = 1;
        batch(4'b0001);
        wait_idle();
        chk("enc_grant_id", 128'(grant_log[0]), 0);
        chk("enc_latency", 128'(last_rsp_cyc - grant_cyc[0]), 3);

        // Decrypt back on requester 2; direction and key held through RESP.
        s_key[2] = FK; s_data[2] = FC; req_decrypt_i[2] = 1'b1; n_left[2] = 1;
        core_lat = 3;
        batch(4'b0100);
        chk("dec_grant_id", 128'(grant_log[0]), 2);
        for (int g = 0; g < 50; g++) begin
            @(negedge clk);
            if (!busy_o) break;
            chk("core_dec_hold", 128'(core_decrypt_o), 1);
            chk("core_key_hold", core_key_o, FK);
        end
        wait_idle();

        // Spurious completion while idle must be ignored.
        spur_cnt++;
        repeat (4) begin
            @(negedge clk);
            chk("spur_idle_busy", 128'(busy_o), 0);
            chk("spur_idle_rsp", 128'(rsp_valid_o), 0);
        end
        @(posedge clk); #1;

        // Round robin from fresh reset with everyone requesting.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            s_data[i] = {32'h1111_0000 + 32'(i), 32'h2222_2222, 32'h3333_3333, 32'h4444_0000 + 32'(i)};
            s_key[i]  = {4{8'(i * 17 + 3), 24'h5a5a5a}};
            req_decrypt_i[i] = i[0];
            n_left[i] = (i == 0) ? 2 : 1;
        end
        core_lat = 2;
        batch(4'b1111);
        wait_idle();
        chk("rr_count", 128'(grant_log.size()), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("rr_order", 128'(grant_log[i]), 128'(exp_rr[i]));

        // Response stall with another requester waiting, plus spurious pulse in RESP.
        rsp_ready_i = 1'b0;
        n_left[1] = 1;
        batch(4'b0010);
        req_valid_i = 4'b1000;
        ok = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (rsp_valid_o) begin ok = 1; break; end
        end
        chk("stall_rsp_seen", 128'(ok), 1);
        held = ref_core(s_key[1], s_data[1], req_decrypt_i[1]);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_valid", 128'(rsp_valid_o), 1);
            chk("stall_id", 128'(rsp_id_o), 1);
            chk("stall_data", rsp_data_o, held);
            chk("stall_busy", 128'(busy_o), 1);
            chk("stall_no_grant", 128'(req_ready_o), 0);
            if (i == 5) spur_cnt++;
        end
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        n_left[3] = 1;
        batch(4'b1000);
        chk("stall_next_id", 128'(grant_log[0]), 3);
        chk("stall_next_cyc", 128'(grant_cyc[0] - last_rsp_cyc), 1);
        wait_idle();

        // Reset while BUSY, then requester 0 regains priority.
        s_key[2] = 128'h0f0e0d0c0b0a09080706050403020100;
        s_data[2] = 128'hffeeddccbbaa99887766554433221100;
        req_decrypt_i[2] = 1'b0; n_left[2] = 1;
        core_lat = 10;
        batch(4'b0100);
        @(posedge clk); #2;
        chk("pre_rst_busy", 128'(busy_o), 1);
        reset = 1'b0;
        #1 chk_reset_vals("rst_busy");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        n_left[0] = 1; n_left[1] = 1; n_left[3] = 1;
        core_lat = 2;
        batch(4'b1011);
        wait_idle();
        chk("post_rst_count", 128'(grant_log.size()), 3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++)
            chk("post_rst_order", 128'(grant_log[i]), 128'(exp_pr[i]));

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
